// File: rtl/dsss_qpsk_mod.sv
// Byte-in, {Q,I}-out direct-sequence spread-spectrum modulator (QPSK/BPSK) with short-code spreading,
// optional upsampling (hold or zero-stuff), a one-word holding buffer and a backpressure-aware output register.
module dsss_qpsk_mod #(
   parameter int                SIZE_INPUT_BIT   = 8,
   parameter int                SIZE_OUTPUT_BIT  = 32,
   parameter int                SPREAD           = 24,
   parameter logic [SPREAD-1:0] PN_CODE          = 24'hAC7259,
   parameter int                SAMPLES_PER_CHIP = 1,
   parameter int                ZERO_STUFF       = 0,
   parameter int                AMPLITUDE        = 8192
) (
   input  logic                         i_clk,
   input  logic                         i_reset,
   input  logic [SIZE_INPUT_BIT-1:0]    i_data,
   input  logic                         i_valid_input,
   input  logic                         i_mode,
   output logic                         o_ready,
   output logic [2*SIZE_OUTPUT_BIT-1:0] o_data,
   output logic                         o_valid_output,
   input  logic                         i_ready_output,
   output logic                         o_last,
   output logic                         o_busy
);

   localparam int W      = SIZE_INPUT_BIT;
   localparam int OW     = SIZE_OUTPUT_BIT;
   localparam int SYM_W  = $clog2(W);
   localparam int CHIP_W = (SPREAD > 1) ? $clog2(SPREAD) : 1;
   localparam int SAMP_W = (SAMPLES_PER_CHIP > 1) ? $clog2(SAMPLES_PER_CHIP) : 1;

   localparam logic [SYM_W-1:0]  SYM_LAST_QPSK = SYM_W'(W / 2 - 1);
   localparam logic [SYM_W-1:0]  SYM_LAST_BPSK = SYM_W'(W - 1);
   localparam logic [CHIP_W-1:0] CHIP_LAST     = CHIP_W'(SPREAD - 1);
   localparam logic [SAMP_W-1:0] SAMP_LAST     = SAMP_W'(SAMPLES_PER_CHIP - 1);
   localparam logic [OW-1:0]     POS_LEVEL     = OW'(AMPLITUDE);
   localparam logic [OW-1:0]     NEG_LEVEL     = OW'(-AMPLITUDE);

   logic [W-1:0]      hold_word;
   logic              hold_mode;
   logic              hold_full;
   logic [W-1:0]      work_word;
   logic              work_mode;
   logic              work_full;
   logic [SYM_W-1:0]  sym_cnt;
   logic [CHIP_W-1:0] chip_cnt;
   logic [SAMP_W-1:0] samp_cnt;
   logic [SPREAD-1:0] pn_sr;
   logic              ready_q;

   logic              accept;
   logic              load_out;
   logic              samp_end;
   logic              chip_end;
   logic              sym_end;
   logic              word_end;
   logic              word_done;
   logic              into_work;
   logic              into_hold;
   logic              hold_full_next;
   logic              chip_i;
   logic              chip_q;
   logic              stuffed;
   logic [OW-1:0]     sample_i;
   logic [OW-1:0]     sample_q;

   // ready is a registered copy of "holding will be empty", masked while reset is asserted
   assign o_ready = ready_q && !i_reset;
   assign o_busy  = work_full || hold_full || o_valid_output;

   always_comb begin
      accept         = i_valid_input && o_ready;
      load_out       = work_full && (!o_valid_output || i_ready_output);
      samp_end       = (samp_cnt == SAMP_LAST);
      chip_end       = (chip_cnt == CHIP_LAST);
      sym_end        = (sym_cnt == (work_mode ? SYM_LAST_BPSK : SYM_LAST_QPSK));
      word_end       = samp_end && chip_end && sym_end;
      word_done      = load_out && word_end;
      into_work      = accept && (!work_full || word_done);
      into_hold      = accept && !into_work;
      hold_full_next = into_hold || (hold_full && !word_done);
      chip_i         = work_word[W-1] ^ pn_sr[SPREAD-1];
      chip_q         = work_word[W-2] ^ pn_sr[SPREAD-1];
      stuffed        = (ZERO_STUFF != 0) && (samp_cnt != '0);
      sample_i       = stuffed ? '0 : (chip_i ? NEG_LEVEL : POS_LEVEL);
      sample_q       = (stuffed || work_mode) ? '0 : (chip_q ? NEG_LEVEL : POS_LEVEL);
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         ready_q   <= 1'b1;
         hold_word <= '0;
         hold_mode <= 1'b0;
         hold_full <= 1'b0;
      end else begin
         ready_q   <= !hold_full_next;
         hold_full <= hold_full_next;
         if (into_hold) begin
            hold_word <= i_data;
            hold_mode <= i_mode;
         end
      end
   end

   // Working word: counters nest sample -> chip -> symbol; a finished word is replaced in the same edge
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         work_word <= '0;
         work_mode <= 1'b0;
         work_full <= 1'b0;
         sym_cnt   <= '0;
         chip_cnt  <= '0;
         samp_cnt  <= '0;
         pn_sr     <= PN_CODE;
      end else if (word_done || !work_full) begin
         sym_cnt  <= '0;
         chip_cnt <= '0;
         samp_cnt <= '0;
         pn_sr    <= PN_CODE;
         if (hold_full) begin
            work_word <= hold_word;
            work_mode <= hold_mode;
            work_full <= 1'b1;
         end else if (into_work) begin
            work_word <= i_data;
            work_mode <= i_mode;
            work_full <= 1'b1;
         end else begin
            work_full <= 1'b0;
         end
      end else if (load_out) begin
         if (samp_end) begin
            samp_cnt <= '0;
            if (chip_end) begin
               chip_cnt  <= '0;
               pn_sr     <= PN_CODE;
               sym_cnt   <= sym_cnt + 1'b1;
               work_word <= work_mode ? (work_word << 1) : (work_word << 2);
            end else begin
               chip_cnt <= chip_cnt + 1'b1;
               pn_sr    <= pn_sr << 1;
            end
         end else begin
            samp_cnt <= samp_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         o_data         <= '0;
         o_valid_output <= 1'b0;
         o_last         <= 1'b0;
      end else if (load_out) begin
         o_data         <= {sample_q, sample_i};
         o_valid_output <= 1'b1;
         o_last         <= word_end;
      end else if (i_ready_output) begin
         o_valid_output <= 1'b0;
         o_last         <= 1'b0;
      end
   end

endmodule

// File: tb/tb_dsss_qpsk_mod.sv
// Directed bench for dsss_qpsk_mod: default core plus a 4x zero-stuffed instance, checked sample by sample.
module tb_dsss_qpsk_mod;

   localparam logic [23:0] PN = 24'hAC7259;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  dataA, dataB;
   logic        validA, validB, modeA, modeB;
   logic        readyA, readyB;
   logic [63:0] oDataA, oDataB;
   logic        oValidA, oValidB, rdyOutA, rdyOutB;
   logic        lastA, lastB, busyA, busyB;

   int          checks = 0;
   int          passes = 0;
   int          fails  = 0;
   int          cyc    = 0;
   logic [64:0] qA[$];
   int          qCyc[$];
   logic [64:0] qB[$];
   logic [64:0] got[$];
   int          gotFirst, gotLast;
   logic        prevStall = 1'b0;
   logic [64:0] prevHeld;
   logic        stallOn;

   always #5 clk = ~clk;

   dsss_qpsk_mod dutA (
      .i_clk(clk), .i_reset(rst), .i_data(dataA), .i_valid_input(validA), .i_mode(modeA),
      .o_ready(readyA), .o_data(oDataA), .o_valid_output(oValidA), .i_ready_output(rdyOutA),
      .o_last(lastA), .o_busy(busyA)
   );

   dsss_qpsk_mod #(.SAMPLES_PER_CHIP(4), .ZERO_STUFF(1)) dutB (
      .i_clk(clk), .i_reset(rst), .i_data(dataB), .i_valid_input(validB), .i_mode(modeB),
      .o_ready(readyB), .o_data(oDataB), .o_valid_output(oValidB), .i_ready_output(rdyOutB),
      .o_last(lastB), .o_busy(busyB)
   );

   task automatic checkOutput(input string tag, input logic [64:0] actual, input logic [64:0] expected);
      checks++;
      if (actual === expected) passes++;
      else begin
         fails++;
         if (fails <= 20) $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Reference sample {last, Q, I} computed straight from the symbol/chip/sample index
   function automatic logic [64:0] modelSample(input logic [7:0] word, input logic mode, input int idx,
                                                input int spc, input bit zs);
      logic [23:0] pn;
      int total, s, r, sym, k;
      logic bI, bQ, pnBit, zero;
      logic [31:0] vi, vq;
      pn    = PN;
      total = (mode ? 8 : 4) * 24 * spc;
      s     = idx / spc;
      r     = idx % spc;
      sym   = s / 24;
      k     = s % 24;
      pnBit = pn[23-k];
      if (mode) begin bI = word[7-sym]; bQ = 1'b0; end
      else begin bI = word[7-2*sym]; bQ = word[6-2*sym]; end
      zero = zs && (r != 0);
      vi = zero ? 32'h0 : ((bI ^ pnBit) ? 32'hFFFFE000 : 32'h00002000);
      vq = (zero || mode) ? 32'h0 : ((bQ ^ pnBit) ? 32'hFFFFE000 : 32'h00002000);
      return {(idx == total - 1), vq, vi};
   endfunction

   always @(posedge clk) cyc++;

   // Collect accepted samples and watch that a stalled sample stays put
   always @(negedge clk) begin
      if (oValidA && rdyOutA) begin
         qA.push_back({lastA, oDataA});
         qCyc.push_back(cyc);
      end
      if (prevStall && oValidA) checkOutput("stall_hold", {lastA, oDataA}, prevHeld);
      prevStall = oValidA && !rdyOutA;
      prevHeld  = {lastA, oDataA};
      if (oValidB && rdyOutB) qB.push_back({lastB, oDataB});
   end

   task automatic applyStimulus(input logic [7:0] d, input logic m);
      int n = 0;
      @(negedge clk);
      while (!readyA && n < 2000) begin @(negedge clk); n++; end
      if (!readyA) begin
         checkOutput("accept_timeout", 65'd0, 65'd1);
         return;
      end
      dataA  = d;
      modeA  = m;
      validA = 1'b1;
      @(posedge clk);
      #1 validA = 1'b0;
   endtask

   task automatic expectWord(input logic [7:0] w, input logic m, input int n);
      logic [64:0] s;
      int c;
      got.delete();
      for (int i = 0; i < n; i++) begin
         int t = 0;
         while (qA.size() == 0 && t < 3000) begin @(negedge clk); t++; end
         if (qA.size() == 0) begin
            checkOutput("sample_timeout", 65'd0, 65'd1);
            return;
         end
         s = qA.pop_front();
         c = qCyc.pop_front();
         if (i == 0) gotFirst = c;
         gotLast = c;
         got.push_back(s);
         checkOutput("sample", s, modelSample(w, m, i, 1, 1'b0));
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int f, l, t;
      rst = 1'b1; validA = 1'b0; validB = 1'b0; dataA = '0; dataB = '0;
      modeA = 1'b0; modeB = 1'b0; rdyOutA = 1'b1; rdyOutB = 1'b1; stallOn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_valid", 65'(oValidA), 65'd0);
      checkOutput("rst_data", 65'(oDataA), 65'd0);
      checkOutput("rst_ready", 65'(readyA), 65'd0);
      checkOutput("rst_busy", 65'(busyA), 65'd0);
      checkOutput("rst_last", 65'(lastA), 65'd0);
      rst = 1'b0;
      #1 checkOutput("ready_after_rst", 65'(readyA), 65'd1);

      $display("[TB] QPSK 8'h00");
      applyStimulus(8'h00, 1'b0);
      checkOutput("lat_edge_n", 65'(oValidA), 65'd0);
      @(posedge clk);
      #1 checkOutput("lat_edge_n1", 65'(oValidA), 65'd1);
      expectWord(8'h00, 1'b0, 96);
      checkOutput("q00_s0", got[0], {1'b0, 32'hFFFFE000, 32'hFFFFE000});
      checkOutput("q00_s1", got[1], {1'b0, 32'h00002000, 32'h00002000});
      checkOutput("q00_last94", 65'(got[94][64]), 65'd0);
      checkOutput("q00_last95", 65'(got[95][64]), 65'd1);

      $display("[TB] QPSK 8'hC0");
      applyStimulus(8'hC0, 1'b0);
      expectWord(8'hC0, 1'b0, 96);
      checkOutput("qc0_s0", got[0], {1'b0, 32'h00002000, 32'h00002000});
      checkOutput("qc0_s24", got[24], {1'b0, 32'hFFFFE000, 32'hFFFFE000});

      $display("[TB] BPSK 8'h80");
      applyStimulus(8'h80, 1'b1);
      expectWord(8'h80, 1'b1, 192);
      checkOutput("b80_s0", got[0], {1'b0, 32'h0, 32'h00002000});
      checkOutput("b80_s24", got[24], {1'b0, 32'h0, 32'hFFFFE000});
      checkOutput("b80_last", 65'(got[191][64]), 65'd1);

      $display("[TB] three words back to back");
      fork
         begin
            applyStimulus(8'h12, 1'b0);
            checkOutput("ready_hold_empty", 65'(readyA), 65'd1);
            applyStimulus(8'h34, 1'b0);
            checkOutput("ready_hold_full", 65'(readyA), 65'd0);
            applyStimulus(8'h56, 1'b0);
         end
         begin
            expectWord(8'h12, 1'b0, 96);
            f = gotFirst;
            expectWord(8'h34, 1'b0, 96);
            expectWord(8'h56, 1'b0, 96);
            l = gotLast;
         end
      join
      checkOutput("no_bubbles", 65'(l - f), 65'd287);

      $display("[TB] random output backpressure");
      stallOn = 1'b1;
      fork
         begin
            applyStimulus(8'h5A, 1'b0);
            applyStimulus(8'hA5, 1'b1);
         end
         begin
            expectWord(8'h5A, 1'b0, 96);
            expectWord(8'hA5, 1'b1, 192);
            stallOn = 1'b0;
         end
         begin
            while (stallOn) begin
               @(posedge clk);
               #1 rdyOutA = 1'($urandom_range(0, 1));
            end
            rdyOutA = 1'b1;
         end
      join
      rdyOutA = 1'b1;

      $display("[TB] reset mid-word");
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'hFF, 1'b0);
      t = 0;
      while (qA.size() < 40 && t < 1000) begin @(negedge clk); t++; end
      rst = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (qA.size() == 0) begin
            checkOutput("rst_pre_timeout", 65'd0, 65'd1);
            break;
         end
         void'(qCyc.pop_front());
         checkOutput("rst_pre_sample", qA.pop_front(), modelSample(8'h00, 1'b0, i, 1, 1'b0));
      end
      @(posedge clk);
      @(negedge clk);
      checkOutput("rst_mid_valid", 65'(oValidA), 65'd0);
      checkOutput("rst_mid_busy", 65'(busyA), 65'd0);
      qA.delete();
      qCyc.delete();
      rst = 1'b0;
      applyStimulus(8'hC0, 1'b0);
      expectWord(8'hC0, 1'b0, 96);
      checkOutput("post_rst_s0", got[0], {1'b0, 32'h00002000, 32'h00002000});

      $display("[TB] 4 samples per chip, zero stuffed");
      qB.delete();
      t = 0;
      @(negedge clk);
      while (!readyB && t < 2000) begin @(negedge clk); t++; end
      checkOutput("b_ready", 65'(readyB), 65'd1);
      dataB = 8'h00; modeB = 1'b0; validB = 1'b1;
      @(posedge clk);
      #1 validB = 1'b0;
      got.delete();
      for (int i = 0; i < 384; i++) begin
         t = 0;
         while (qB.size() == 0 && t < 3000) begin @(negedge clk); t++; end
         if (qB.size() == 0) begin
            checkOutput("zs_timeout", 65'd0, 65'd1);
            break;
         end
         got.push_back(qB.pop_front());
         checkOutput("zs_sample", got[i], modelSample(8'h00, 1'b0, i, 4, 1'b1));
      end
      checkOutput("zs_s0", got[0], {1'b0, 32'hFFFFE000, 32'hFFFFE000});
      checkOutput("zs_s1", got[1], 65'd0);
      checkOutput("zs_s4", got[4], {1'b0, 32'h00002000, 32'h00002000});
      checkOutput("zs_last", 65'(got[383][64]), 65'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/dsss_qpsk_mod.md
Name: dsss_qpsk_mod

Overview:
- Parametrised spread-spectrum modulator core, successor to the fixed byte→pack→spread(24)→QPSK chain.
- Takes bytes on a valid/ready input and serialises them MSB-first. Maps bits onto QPSK or BPSK symbols, spreads each symbol with a programmable short code and optionally upsamples.
- Emits signed {Q,I} samples on a valid/ready output that honours downstream backpressure.
- Feeds the external FIR shaping filter.

Parameters:
- SIZE_INPUT_BIT, 8, input word width; must be even, ≥2.
- SIZE_OUTPUT_BIT, 32, width of each of I and Q (signed two's complement).
- SPREAD, 24, chips per symbol; ≥1.
- PN_CODE, 24'hAC7259, SPREAD-bit spreading code; chip k of every symbol = PN_CODE[SPREAD-1-k].
- SAMPLES_PER_CHIP, 1, output samples per chip; ≥1.
- ZERO_STUFF, 0, upsampling mode:
  - 0: chip value held for all SAMPLES_PER_CHIP samples.
  - 1: first sample carries the chip, the remaining samples are 0.
- AMPLITUDE, 8192, positive magnitude of a mapped chip; must be < 2**(SIZE_OUTPUT_BIT-1).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_data  in  SIZE_INPUT_BIT  input byte
- i_valid_input  in  1  input valid
- i_mode  in  1  modulation mode, sampled with each accepted word: 0 = QPSK, 1 = BPSK
- o_ready  out  1  core can accept a word this cycle
- o_data  out  2*SIZE_OUTPUT_BIT  output sample: [2*SIZE_OUTPUT_BIT-1:SIZE_OUTPUT_BIT] = Q, [SIZE_OUTPUT_BIT-1:0] = I
- o_valid_output  out  1  o_data valid
- i_ready_output  in  1  downstream accepts sample
- o_last  out  1  qualifies o_data: last sample of current input word
- o_busy  out  1  any word held in the core or any sample pending in the output register

Behaviour:
- Clock and reset:
  - Single clock domain; one clock i_clk.
  - Reset is synchronous and active-high on i_reset.
  - Reset values: o_valid_output=0, o_last=0, o_data=0, o_busy=0, o_ready=0 while i_reset=1.
  - o_ready=1 on the first cycle after release.
  - All buffers and counters clear.
- Storage:
  - Holding buffer: 1 word + mode.
  - Working shift register: 1 word + mode.
  - Bit, chip and sample counters.
  - One output register.
- Input handshake:
  - Transfer occurs when i_valid_input && o_ready.
  - o_ready = !holding_full. It is registered and has no combinational path from i_ready_output.
  - If working is empty (or its last sample is being loaded into the output register this cycle) the accepted word goes straight to working; otherwise it goes to holding.
  - Holding moves to working on the cycle working's last sample is loaded.
- Output handshake:
  - Output register loads when (!o_valid_output || i_ready_output) and working is non-empty.
  - While o_valid_output && !i_ready_output, o_data and o_last are held stable.
  - Latency: word accepted at edge N with core idle → o_valid_output=1 after edge N+1.
- Back-to-back throughput:
  - With continuous valid and ready there are no bubbles between words.
  - One sample per cycle.
- Symbol formation:
  - QPSK: each symbol takes 2 bits, MSB-first; first bit → b_I, second bit → b_Q. Gives SIZE_INPUT_BIT/2 symbols per word.
  - BPSK: each symbol takes 1 bit; b_I = bit, Q output forced to 0. Gives SIZE_INPUT_BIT symbols per word.
- Spreading:
  - chip_I = b_I XOR PN_CODE[SPREAD-1-k], chip_Q = b_Q XOR PN_CODE[SPREAD-1-k], k = 0..SPREAD-1.
  - k restarts at 0 on every symbol.
- Mapping:
  - chip 0 → +AMPLITUDE, chip 1 → -AMPLITUDE.
  - Values are sign-extended to SIZE_OUTPUT_BIT.
  - Zero-stuffed samples are exactly 0.
- Samples per word:
  - QPSK: (SIZE_INPUT_BIT/2)*SPREAD*SAMPLES_PER_CHIP; defaults give 96.
  - BPSK: SIZE_INPUT_BIT*SPREAD*SAMPLES_PER_CHIP; defaults give 192.
- Counter order: sample counter is innermost, then chip counter, then bit/symbol counter. All wrap to 0 at the word boundary.
- o_last is 1 only on the final sample of a word.
- Mode:
  - i_mode is latched with the word.
  - Changing i_mode mid-word has no effect on the word in flight.
- Simultaneous events: input accept in the same cycle as working's last-sample load → new word enters working directly and its first sample loads next cycle (no gap).
- Full: holding full → o_ready=0. i_valid_input is ignored and i_data is not captured.
- Reset mid-word: the in-flight word, the holding word and the pending sample are discarded.
  - o_valid_output=0 on the cycle after reset is sampled.
  - The next word after reset starts at symbol 0, chip 0.

Test Plan:
- Reset release, i_data=8'h00, QPSK, i_ready_output=1:
  - 96 samples.
  - Sample 0 = {32'hFFFFE000, 32'hFFFFE000} (PN bit 1).
  - Sample 1 = {32'h00002000, 32'h00002000}.
  - o_last only on sample 95.
  - o_valid_output rises the cycle after accept.
- 8'hC0 QPSK:
  - Symbol 0 (b_I=1, b_Q=1) chips are the inverted PN: sample 0 = {32'h00002000, 32'h00002000}.
  - Symbols 1-3 match the 8'h00 case.
- 8'h80 BPSK:
  - 192 samples, Q always 0.
  - I in samples 0-23 is the inverted-PN pattern.
  - I in samples 24-191 is the plain-PN pattern.
- Three words back-to-back, i_ready_output=1:
  - 288 consecutive valid cycles, no bubbles.
  - o_ready drops only while holding is full.
- i_ready_output toggled pseudo-randomly:
  - o_data stable whenever valid && !ready.
  - Sample sequence identical to the stall-free run.
- SAMPLES_PER_CHIP=4, ZERO_STUFF=1:
  - Each chip gives 1 mapped sample followed by 3 samples of 0 on both I and Q.
- i_reset pulsed at sample 40 of a word:
  - Next cycle o_valid_output=0, o_busy=0.
  - Next word's first sample equals sample 0 of the expected sequence.
